uart_rx_8n1: RTL
================

// Module: uart_rx_8n1
// PURPOSE
//  UART 8N1 receiver: the receive-side counterpart of uart_tx_8n1, sitting on
//  the uartrx pin ahead of any byte consumer.
//  Runs on the 12 MHz system clock and samples at bit centres using a baud
//  counter, so no divided clock is needed.
//  Delivers each byte through a one-entry valid/ready holding register.
//  Flags framing errors and overruns.
// PARAMETERS
//  CLKS_PER_BIT  1250  system clocks per bit (12 MHz / 9600); legal range >= 8
//  CNT_W         $clog2(CLKS_PER_BIT)  baud counter width (derived; do not override)
// PORTS
//  clk        in   1  system clock (12 MHz); single clock domain
//  rst_n      in   1  asynchronous, active-low reset
//  rxd        in   1  raw serial input (asynchronous to clk, idle high)
//  rx_data    out  8  received byte; valid while rx_valid=1
//  rx_valid   out  1  holding register full; held until accepted
//  rx_ready   in   1  consumer accepts rx_data when rx_valid&rx_ready at posedge clk
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  overrun    out  1  one-cycle pulse: byte completed while holding reg full, not accepted
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
//   - Counters=0; both synchroniser flops=1 (idle line).
//  Input sync: rxd passes through 2 flops -> rxd_s; only rxd_s is used internally.
//  FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
//   - IDLE: rxd_s=0 -> START, cnt=0.
//   - START: cnt counts up. At cnt==CLKS_PER_BIT/2-1, sample rxd_s:
//     =1 -> IDLE (glitch rejected, no output); =0 -> DATA, cnt=0, bit_idx=0.
//   - DATA: at cnt==CLKS_PER_BIT-1, shift rxd_s in LSB-first, cnt=0, bit_idx++.
//     After the 8th bit -> STOP.
//   - STOP: at cnt==CLKS_PER_BIT-1, sample rxd_s:
//     =1 -> byte complete, -> IDLE.
//     =0 -> frame_err pulse, byte discarded, -> WAIT_IDLE.
//   - WAIT_IDLE: stays until rxd_s=1, then -> IDLE. A break never re-triggers START.
//  Holding register, evaluated on the byte-complete cycle:
//   - rx_valid=0, or rx_valid&rx_ready: load rx_data, rx_valid=1 next cycle.
//   - rx_valid&!rx_ready: new byte dropped, old data kept, overrun pulse.
//   - Otherwise rx_valid&rx_ready clears rx_valid next cycle; rx_data holds its last value.
//  Latency: rx_valid rises 1 clk after the stop-bit sample cycle. From the rxd
//   falling edge that is 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 clks,
//   +/-1 for edge phase.
//  Counters saturate never; cnt always reloads to 0 at each sample point.
//  rx_valid is unaffected by frame_err and by FSM state.
//  Reset mid-frame aborts immediately; the next frame must start from IDLE.
// TESTING
//  1. Send 0x52 ('R') at CLKS_PER_BIT=1250, rx_ready=1
//     -> rx_valid 1 cycle, rx_data=0x52, no err/overrun, busy low after.
//  2. Send 0x00 then 0xFF back-to-back, rx_ready=1
//     -> two valid beats, 0x00 then 0xFF, in order.
//  3. 300-clk low glitch on rxd (< CLKS_PER_BIT/2)
//     -> state returns IDLE, no rx_valid, no frame_err.
//  4. Send 0xA5 with stop bit forced low, then hold rxd low 3 bit times
//     -> one frame_err pulse, no rx_valid, busy until rxd high, no second frame.
//  5. rx_ready=0, send 0x11 then 0x22
//     -> rx_data stays 0x11, overrun pulses once at byte 2; raise rx_ready -> rx_valid clears.
//  6. Assert rst_n=0 mid-DATA of 0x3C, release, send 0xC3
//     -> outputs zero during reset, only 0xC3 delivered.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: received byte, valid/ready and status pulses.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-flop input sync, bit-centre sampling via baud counter,
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  uart_rx_if.master   rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       sync_q, sync_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             rxd_s;
  logic             done;

  assign rxd_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], rxd};
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done      = 1'b0;
    fe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (cnt_q == HALF_M1) begin
        // Mid start bit: a line already back high was only a glitch.
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
        else begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: if (cnt_q == FULL_M1) begin
        cnt_d     = '0;
        shift_d   = {rxd_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        if (rxd_s) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line idles so a break cannot start a new frame.
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (done) begin
      if (!valid_q || rx.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && rx.rx_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sync_q    <= 2'b11;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sync_q    <= sync_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      busy_q    <= busy_d;
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = fe_q;
  assign rx.overrun   = ov_q;
  assign rx.busy      = busy_q;

endmodule
